// File: rtl/decoder_3x8.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_3x8
//  Purpose  : 3-to-8 one-hot decoder for register/ALU select. O is a purely
//             combinational decode of I; O_q is the same decode registered
//             on clk, cleared asynchronously by rst_n.
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_3x8 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] I,
   output logic [7:0] O,
   output logic [7:0] O_q
);

   logic [7:0] w_dec;
   logic [7:0] r_dec_q;

   // One-hot decode; an unknown select propagates as all-X instead of
   // silently decoding to some legal code.
   always_comb begin
      w_dec = 8'h00;
      case (I)
         3'd0:    w_dec = 8'b0000_0001;
         3'd1:    w_dec = 8'b0000_0010;
         3'd2:    w_dec = 8'b0000_0100;
         3'd3:    w_dec = 8'b0000_1000;
         3'd4:    w_dec = 8'b0001_0000;
         3'd5:    w_dec = 8'b0010_0000;
         3'd6:    w_dec = 8'b0100_0000;
         3'd7:    w_dec = 8'b1000_0000;
         default: w_dec = 8'bxxxx_xxxx;
      endcase
   end

   // Pipelined copy of the decode; reset clears it without waiting for clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dec_q <= 8'h00;
      end else begin
         r_dec_q <= w_dec;
      end
   end

   assign O   = w_dec;
   assign O_q = r_dec_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3x8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_3x8
//  Purpose  : Self-checking bench for decoder_3x8 with an arithmetic
//             reference model (power of two of the select index).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_3x8;

   logic       clk;
   logic       rst_n;
   logic [2:0] I;
   logic [7:0] O;
   logic [7:0] O_q;

   int  n_checks;
   int  n_fail;
   bit  clk_run;
   bit  cmp_en;
   logic [7:0] exp_q;

   decoder_3x8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .I     (I),
      .O     (O),
      .O_q   (O_q)
   );

   // Clock runs only when enabled so the combinational path can be checked idle.
   always #5 if (clk_run) clk = ~clk;

   // Reference: the selected bit is the power of two given by the index.
   function automatic logic [7:0] model(input logic [2:0] sel);
      int unsigned v;
      v = 1;
      for (int k = 0; k < int'(sel); k++) v = v * 2;
      return v[7:0];
   endfunction

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model of the registered output: previous-edge decode, cleared by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) exp_q = 8'h00;
      else        exp_q = model(I);
   end

   // Per-cycle compare during the randomized phase, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check8("rand_O", O, model(I));
         check8("rand_O_q", O_q, exp_q);
         n_checks++;
         if ($countones(O_q) != 1) begin
            n_fail++;
            $display("FAIL rand_onehot: O_q=%b has %0d bits set, required 1", O_q, $countones(O_q));
         end
      end
   end

   initial begin
      logic [7:0] lit [8];
      logic       probe;
      lit = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      n_checks = 0;
      n_fail   = 0;
      clk      = 1'b0;
      clk_run  = 1'b0;
      cmp_en   = 1'b0;
      rst_n    = 1'b0;
      I        = 3'd0;
      #1;
      check8("reset_O_q", O_q, 8'h00);

      // Idle clock, reset asserted: O must still decode every index.
      for (int i = 0; i < 8; i++) begin
         I = 3'(i);
         #1;
         check8("sweep_lit", O, lit[i]);
         check8("sweep_model", O, model(I));
      end

      // Clock running with reset held: O_q stays cleared, O tracks I.
      clk_run = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1 I = 3'($urandom_range(7));
         @(negedge clk);
         check8("hold_O_q", O_q, 8'h00);
         check8("hold_O", O, model(I));
      end

      // Release and first updates.
      rst_n = 1'b1;
      I = 3'b101;
      @(posedge clk);
      #1 check8("release_5", O_q, 8'h20);
      I = 3'b000;
      @(posedge clk);
      #1 check8("release_0", O_q, 8'h01);

      // Asynchronous reset between edges.
      I = 3'd7;
      @(posedge clk);
      #1 check8("pre_async", O_q, 8'h80);
      #2 rst_n = 1'b0;
      #1;
      check8("async_O_q", O_q, 8'h00);
      check8("async_O", O, 8'h80);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 I = 3'($urandom_range(7));

      // Randomized run: one new select per cycle.
      @(posedge clk);
      #1 cmp_en = 1'b1;
      for (int c = 0; c < 100; c++) begin
         I = 3'($urandom_range(7));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      cmp_en = 1'b0;

      // Unknown select must not decode to a legal code (4-state simulators only).
      probe = 1'bx;
      if ($isunknown(probe)) begin
         I = 3'bx1x;
         #1;
         check8("x_select", O, 8'bxxxx_xxxx);
      end

      clk_run = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
